// File: rtl/text_line_render_pkg.sv
// Shared constants, types and elaboration helpers for the hex text-line renderer.
package text_pkg;

   localparam int FONT_W = 8;
   localparam int FONT_H = 8;

   typedef logic [3:0] glyph_code_t;

   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit scale_legal(input int s);
      return (s == 1) || (s == 2) || (s == 4) || (s == 8);
   endfunction

endpackage

// File: rtl/text_line_render_if.sv
// Video-side bus of the text-line renderer; TEXT_BLINK_EN adds the per-char blink mask.
interface text_line_render_if #(
   parameter int N_CHARS = 8
);
   logic                   valid;
   logic                   frame_start;
   logic [9:0]             x;
   logic [9:0]             y;
   logic [4*N_CHARS-1:0]   line;
`ifdef TEXT_BLINK_EN
   logic [N_CHARS-1:0]     blink_mask;
`endif
   logic                   pix;
   logic                   pix_valid;

`ifdef TEXT_BLINK_EN
   modport master (output valid, frame_start, x, y, line, blink_mask, input pix, pix_valid);
   modport slave  (input valid, frame_start, x, y, line, blink_mask, output pix, pix_valid);
`else
   modport master (output valid, frame_start, x, y, line, input pix, pix_valid);
   modport slave  (input valid, frame_start, x, y, line, output pix, pix_valid);
`endif
endinterface

// File: rtl/text_line_render_hex_font_rom.sv
// 8x8 hex-digit font (0-9, A-F); one registered row read per cycle, bit 7 is the leftmost column.
module hex_font_rom
   import text_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  glyph_code_t code,
   input  logic [2:0]  row,
   output logic [7:0]  row_bits
);

   localparam logic [63:0] GLYPHS [16] = '{
      64'h3C666E7666663C00, 64'h183818181818_7E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
      64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
      64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
      64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000
   };

   logic [63:0] glyph_s;

   assign glyph_s = GLYPHS[code];

   // Row 0 sits in the top byte of each packed glyph.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_bits <= 8'h00;
      end else if (en) begin
         row_bits <= glyph_s[{~row, 3'b111} -: 8];
      end else begin
         row_bits <= row_bits;
      end
   end

endmodule

// File: rtl/text_line_render.sv
// Renders a shadowed line of hex digits into a rectangular area of the raster, 3-cycle latency.
// Optional build macro TEXT_BLINK_EN adds per-character blinking driven by a frame counter.
module text_line_render
   import text_pkg::*;
#(
   parameter int N_CHARS = 8,
   parameter int X0      = 16,
   parameter int Y0      = 300,
   parameter int SCALE   = 1,
   parameter int GAP     = 0
)(
   input logic               clk,
   input logic               rst,
   text_line_render_if.slave bus
);

   localparam int CELL_W     = FONT_W + GAP;
   localparam int X_END      = X0 + N_CHARS * CELL_W * SCALE;
   localparam int Y_END      = Y0 + FONT_H * SCALE;
   localparam int LOG2_SCALE = clog2_f(SCALE);
   localparam int SUB_W      = clog2_f(SCALE + 1);
   localparam int COL_W      = clog2_f(CELL_W + 1);
   localparam int CHR_W      = clog2_f(N_CHARS + 1);

   generate
      if (!scale_legal(SCALE)) begin : g_bad_scale
         $error("text_line_render: SCALE must be 1, 2, 4 or 8");
      end
      if ((GAP < 0) || (GAP > 7)) begin : g_bad_gap
         $error("text_line_render: GAP must be within 0..7");
      end
   endgenerate

   logic [1:0]             rst_sync_r;
   logic                   rst_n_s;
   logic [4*N_CHARS-1:0]   shadow_line_r;
   logic [SUB_W-1:0]       sub_cnt_r, cur_sub_s, nxt_sub_s;
   logic [COL_W-1:0]       col_cnt_r, cur_col_s, nxt_col_s;
   logic [CHR_W-1:0]       chr_cnt_r, cur_chr_s, nxt_chr_s;
   logic                   in_x_s, in_y_s, at_x0_s, blank_s, show_s;
   logic [9:0]             y_off_s;
   logic [2:0]             row_s;
   glyph_code_t            code_s;
   logic                   s1_valid_r, s1_show_r;
   glyph_code_t            s1_code_r;
   logic [2:0]             s1_row_r, s1_col_r;
   logic                   s2_valid_r, s2_show_r;
   logic [2:0]             s2_col_r;
   logic [7:0]             font_bits_s;
   logic                   pix_r, pix_valid_r;

   // Reset asserts asynchronously but is released only on a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_r[1];

`ifdef TEXT_BLINK_EN
   logic [N_CHARS-1:0] shadow_mask_r;
   logic [5:0]         blink_cnt_r;

   // Blink mask is shadowed with the text; frame counter bit 5 gives 32 frames on / 32 off.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         shadow_mask_r <= '0;
         blink_cnt_r   <= 6'd0;
      end else if (bus.frame_start) begin
         shadow_mask_r <= bus.blink_mask;
         blink_cnt_r   <= blink_cnt_r + 6'd1;
      end else begin
         shadow_mask_r <= shadow_mask_r;
         blink_cnt_r   <= blink_cnt_r;
      end
   end

   assign blank_s = shadow_mask_r[cur_chr_s] & blink_cnt_r[5];
`else
   assign blank_s = 1'b0;
`endif

   // Text shadow: rendering never sees the live line input, so a frame cannot tear.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         shadow_line_r <= '0;
      end else if (bus.frame_start) begin
         shadow_line_r <= bus.line;
      end else begin
         shadow_line_r <= shadow_line_r;
      end
   end

   // Area decode, effective position (forced to zero at X0) and the following position.
   always_comb begin
      in_x_s    = ({1'b0, bus.x} >= 11'(X0)) && ({1'b0, bus.x} < 11'(X_END));
      in_y_s    = ({1'b0, bus.y} >= 11'(Y0)) && ({1'b0, bus.y} < 11'(Y_END));
      at_x0_s   = (bus.x == 10'(X0));
      y_off_s   = bus.y - 10'(Y0);
      row_s     = 3'(y_off_s >> LOG2_SCALE);
      cur_sub_s = sub_cnt_r;
      cur_col_s = col_cnt_r;
      cur_chr_s = chr_cnt_r;
      if (at_x0_s) begin
         cur_sub_s = '0;
         cur_col_s = '0;
         cur_chr_s = '0;
      end else begin
         cur_sub_s = sub_cnt_r;
         cur_col_s = col_cnt_r;
         cur_chr_s = chr_cnt_r;
      end
      nxt_sub_s = cur_sub_s;
      nxt_col_s = cur_col_s;
      nxt_chr_s = cur_chr_s;
      if (cur_sub_s == SUB_W'(SCALE - 1)) begin
         nxt_sub_s = '0;
         if (cur_col_s == COL_W'(CELL_W - 1)) begin
            nxt_col_s = '0;
            if (cur_chr_s == CHR_W'(N_CHARS - 1)) begin
               nxt_chr_s = '0;
            end else begin
               nxt_chr_s = cur_chr_s + CHR_W'(1);
            end
         end else begin
            nxt_col_s = cur_col_s + COL_W'(1);
         end
      end else begin
         nxt_sub_s = cur_sub_s + SUB_W'(1);
      end
      code_s = shadow_line_r[{cur_chr_s, 2'b00} +: 4];
      show_s = bus.valid && in_x_s && in_y_s && (cur_col_s < COL_W'(FONT_W)) && !blank_s;
   end

   // Position counters step only on valid in-area pixels and hold otherwise.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         sub_cnt_r <= '0;
         col_cnt_r <= '0;
         chr_cnt_r <= '0;
      end else if (bus.valid && in_x_s) begin
         sub_cnt_r <= nxt_sub_s;
         col_cnt_r <= nxt_col_s;
         chr_cnt_r <= nxt_chr_s;
      end else begin
         sub_cnt_r <= sub_cnt_r;
         col_cnt_r <= col_cnt_r;
         chr_cnt_r <= chr_cnt_r;
      end
   end

   // S1 captures the decoded pixel; S2 is the ROM read plus its side-band.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         s1_valid_r <= 1'b0;
         s1_show_r  <= 1'b0;
         s1_code_r  <= 4'h0;
         s1_row_r   <= 3'd0;
         s1_col_r   <= 3'd0;
         s2_valid_r <= 1'b0;
         s2_show_r  <= 1'b0;
         s2_col_r   <= 3'd0;
      end else begin
         s1_valid_r <= bus.valid;
         s1_show_r  <= show_s;
         s1_code_r  <= code_s;
         s1_row_r   <= row_s;
         s1_col_r   <= cur_col_s[2:0];
         s2_valid_r <= s1_valid_r;
         s2_show_r  <= s1_show_r;
         s2_col_r   <= s1_col_r;
      end
   end

   hex_font_rom u_font (
      .clk      (clk),
      .rst_n    (rst_n_s),
      .en       (1'b1),
      .code     (s1_code_r),
      .row      (s1_row_r),
      .row_bits (font_bits_s)
   );

   // S3 selects the glyph bit; pix is forced low whenever its strobe is low.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         pix_r       <= 1'b0;
         pix_valid_r <= 1'b0;
      end else begin
         pix_r       <= s2_valid_r & s2_show_r & font_bits_s[3'd7 - s2_col_r];
         pix_valid_r <= s2_valid_r;
      end
   end

   assign bus.pix       = pix_r;
   assign bus.pix_valid = pix_valid_r;

endmodule
